// File: rtl/l2_cache_write_pkg.sv
// Shared L2 request definitions for the cache-write stage: opcodes, core sizing and
// the byte-masked line merge.
package l2_cache_write_pkg;

  localparam int NUM_CORES        = 1;
  localparam int CORE_INDEX_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_FLUSH       = 3'd2,
    L2REQ_DINVALIDATE = 3'd3,
    L2REQ_IINVALIDATE = 3'd4,
    L2REQ_LOAD_SYNC   = 3'd5,
    L2REQ_STORE_SYNC  = 3'd6
  } l2req_op_t;

  typedef struct packed {
    logic [CORE_INDEX_WIDTH-1:0] core;
    logic [1:0]                  unit;
    logic [1:0]                  strand;
    l2req_op_t                   op;
    logic [1:0]                  way;
    logic [25:0]                 address;
  } l2req_t;

  function automatic logic [511:0] merge_line(input logic [511:0] base,
                                              input logic [511:0] data,
                                              input logic [63:0]  mask);
    logic [511:0] res;
    for (int i = 0; i < 64; i++)
      res[8*i +: 8] = mask[i] ? data[8*i +: 8] : base[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/l2_cache_write_if.sv
// Directory-stage request bundle in, registered wr_* bundle out.
interface l2_cache_write_if
  import l2_cache_write_pkg::*;
#(
  parameter int SET_INDEX_WIDTH = 6
) ();
  logic                        dir_l2req_valid;
  logic [CORE_INDEX_WIDTH-1:0] dir_l2req_core;
  logic [1:0]                  dir_l2req_unit;
  logic [1:0]                  dir_l2req_strand;
  l2req_op_t                   dir_l2req_op;
  logic [1:0]                  dir_l2req_way;
  logic [25:0]                 dir_l2req_address;
  logic [511:0]                dir_l2req_data;
  logic [63:0]                 dir_l2req_mask;
  logic                        dir_cache_hit;
  logic                        dir_is_l2_fill;
  logic [511:0]                dir_old_data;
  logic [511:0]                dir_fill_data;
  logic [NUM_CORES-1:0]        dir_l1_has_line;
  logic [NUM_CORES*2-1:0]      dir_dir_l1_way;

  logic                        wr_l2req_valid;
  logic [CORE_INDEX_WIDTH-1:0] wr_l2req_core;
  logic [1:0]                  wr_l2req_unit;
  logic [1:0]                  wr_l2req_strand;
  l2req_op_t                   wr_l2req_op;
  logic [1:0]                  wr_l2req_way;
  logic [25:0]                 wr_l2req_address;
  logic [NUM_CORES-1:0]        wr_l1_has_line;
  logic [NUM_CORES*2-1:0]      wr_dir_l1_way;
  logic                        wr_cache_hit;
  logic                        wr_is_l2_fill;
  logic [511:0]                wr_data;
  logic                        wr_store_sync_success;
  logic                        wr_cache_write_en;
  logic [SET_INDEX_WIDTH+1:0]  wr_cache_write_index;

  modport slave (
    input  dir_l2req_valid, dir_l2req_core, dir_l2req_unit, dir_l2req_strand, dir_l2req_op,
           dir_l2req_way, dir_l2req_address, dir_l2req_data, dir_l2req_mask, dir_cache_hit,
           dir_is_l2_fill, dir_old_data, dir_fill_data, dir_l1_has_line, dir_dir_l1_way,
    output wr_l2req_valid, wr_l2req_core, wr_l2req_unit, wr_l2req_strand, wr_l2req_op,
           wr_l2req_way, wr_l2req_address, wr_l1_has_line, wr_dir_l1_way, wr_cache_hit,
           wr_is_l2_fill, wr_data, wr_store_sync_success, wr_cache_write_en, wr_cache_write_index
  );

  modport master (
    output dir_l2req_valid, dir_l2req_core, dir_l2req_unit, dir_l2req_strand, dir_l2req_op,
           dir_l2req_way, dir_l2req_address, dir_l2req_data, dir_l2req_mask, dir_cache_hit,
           dir_is_l2_fill, dir_old_data, dir_fill_data, dir_l1_has_line, dir_dir_l1_way,
    input  wr_l2req_valid, wr_l2req_core, wr_l2req_unit, wr_l2req_strand, wr_l2req_op,
           wr_l2req_way, wr_l2req_address, wr_l1_has_line, wr_dir_l1_way, wr_cache_hit,
           wr_is_l2_fill, wr_data, wr_store_sync_success, wr_cache_write_en, wr_cache_write_index
  );
endinterface

// File: rtl/l2_cache_write_sync_tracker.sv
// Load-linked/store-conditional link table next-state logic; one entry per hardware thread.
module l2_cache_sync_tracker #(
  parameter int THREADS = 4,
  parameter int TID_W   = 3
) (
  input  logic [THREADS-1:0]        link_valid_i,
  input  logic [THREADS-1:0][25:0]  link_addr_i,
  input  logic [TID_W-1:0]          tid_i,
  input  logic [25:0]               addr_i,
  input  logic                      set_i,
  input  logic                      check_i,
  input  logic                      store_commit_i,
  output logic                      success_o,
  output logic                      commit_o,
  output logic [THREADS-1:0]        link_valid_o,
  output logic [THREADS-1:0][25:0]  link_addr_o
);

  always_comb begin
    success_o = 1'b0;
    for (int t = 0; t < THREADS; t++)
      if (TID_W'(t) == tid_i)
        success_o = link_valid_i[t] && (link_addr_i[t] == addr_i);
  end

  assign commit_o = store_commit_i || (check_i && success_o);

  // Per-entry priority: committed-store clear, then own check clear, then own set.
  always_comb begin
    link_valid_o = link_valid_i;
    link_addr_o  = link_addr_i;
    for (int t = 0; t < THREADS; t++) begin
      if (commit_o && link_valid_i[t] && (link_addr_i[t] == addr_i))
        link_valid_o[t] = 1'b0;
      if (check_i && (TID_W'(t) == tid_i))
        link_valid_o[t] = 1'b0;
      if (set_i && (TID_W'(t) == tid_i)) begin
        link_valid_o[t] = 1'b1;
        link_addr_o[t]  = addr_i;
      end
    end
  end

endmodule

// File: rtl/l2_cache_write.sv
// L2 cache-write stage: store merge, data-SRAM write strobe and sync evaluation, one cycle.
// Optional L2_WRITE_BYPASS_EN forwards the previous write line to a same-{set,way} hit.
module l2_cache_write
  import l2_cache_write_pkg::*;
#(
  parameter int SET_INDEX_WIDTH = 6
) (
  input logic             clk,
  input logic             reset,
  l2_cache_write_if.slave bus
);

  localparam int THREADS = NUM_CORES * 4;
  localparam int TID_W   = CORE_INDEX_WIDTH + 2;

  logic                       valid_q, hit_q, fill_q, sync_q, we_q;
  l2req_t                     req_d, req_q;
  logic [NUM_CORES-1:0]       l1_has_q;
  logic [NUM_CORES*2-1:0]     l1_way_q;
  logic [511:0]               data_d, data_q, base;
  logic [SET_INDEX_WIDTH+1:0] idx_d, idx_q;
  logic [THREADS-1:0]         link_valid_q, link_valid_d;
  logic [THREADS-1:0][25:0]   link_addr_q, link_addr_d;

  logic hit_or_fill, link_set, link_check, plain_commit, sync_ok, commit;
  logic merge_en, we_d, sync_d;

  assign req_d = '{core: bus.dir_l2req_core, unit: bus.dir_l2req_unit,
                   strand: bus.dir_l2req_strand, op: bus.dir_l2req_op,
                   way: bus.dir_l2req_way, address: bus.dir_l2req_address};

  assign idx_d        = {bus.dir_l2req_address[SET_INDEX_WIDTH-1:0], bus.dir_l2req_way};
  assign hit_or_fill  = bus.dir_cache_hit || bus.dir_is_l2_fill;
  assign link_set     = bus.dir_l2req_valid && hit_or_fill && (bus.dir_l2req_op == L2REQ_LOAD_SYNC);
  assign link_check   = bus.dir_l2req_valid && hit_or_fill && (bus.dir_l2req_op == L2REQ_STORE_SYNC);
  assign plain_commit = bus.dir_l2req_valid && hit_or_fill && (bus.dir_l2req_op == L2REQ_STORE);

`ifdef L2_WRITE_BYPASS_EN
  // The registered write of last cycle has not landed in the SRAM read this cycle saw.
  logic bypass;
  assign bypass = bus.dir_l2req_valid && we_q && bus.dir_cache_hit && !bus.dir_is_l2_fill
                  && (idx_d == idx_q);
  assign base = bypass ? data_q : (bus.dir_is_l2_fill ? bus.dir_fill_data : bus.dir_old_data);
`else
  assign base = bus.dir_is_l2_fill ? bus.dir_fill_data : bus.dir_old_data;
`endif

  l2_cache_sync_tracker #(.THREADS(THREADS), .TID_W(TID_W)) u_sync (
    .link_valid_i   (link_valid_q),
    .link_addr_i    (link_addr_q),
    .tid_i          ({bus.dir_l2req_core, bus.dir_l2req_strand}),
    .addr_i         (bus.dir_l2req_address),
    .set_i          (link_set),
    .check_i        (link_check),
    .store_commit_i (plain_commit),
    .success_o      (sync_ok),
    .commit_o       (commit),
    .link_valid_o   (link_valid_d),
    .link_addr_o    (link_addr_d)
  );

  // A failed STORE_SYNC fill still writes, but with the untouched fill line.
  assign merge_en = (bus.dir_l2req_op == L2REQ_STORE) || (link_check && sync_ok);
  assign data_d   = merge_en ? merge_line(base, bus.dir_l2req_data, bus.dir_l2req_mask) : base;
  assign we_d     = bus.dir_l2req_valid && (bus.dir_is_l2_fill || commit);
  assign sync_d   = link_check && sync_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      req_q        <= '0;
      l1_has_q     <= '0;
      l1_way_q     <= '0;
      hit_q        <= 1'b0;
      fill_q       <= 1'b0;
      data_q       <= '0;
      sync_q       <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      link_valid_q <= '0;
      link_addr_q  <= '0;
    end else begin
      valid_q      <= bus.dir_l2req_valid;
      req_q        <= req_d;
      l1_has_q     <= bus.dir_l1_has_line;
      l1_way_q     <= bus.dir_dir_l1_way;
      hit_q        <= bus.dir_cache_hit;
      fill_q       <= bus.dir_is_l2_fill;
      data_q       <= data_d;
      sync_q       <= sync_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign bus.wr_l2req_valid        = valid_q;
  assign bus.wr_l2req_core         = req_q.core;
  assign bus.wr_l2req_unit         = req_q.unit;
  assign bus.wr_l2req_strand       = req_q.strand;
  assign bus.wr_l2req_op           = req_q.op;
  assign bus.wr_l2req_way          = req_q.way;
  assign bus.wr_l2req_address      = req_q.address;
  assign bus.wr_l1_has_line        = l1_has_q;
  assign bus.wr_dir_l1_way         = l1_way_q;
  assign bus.wr_cache_hit          = hit_q;
  assign bus.wr_is_l2_fill         = fill_q;
  assign bus.wr_data               = data_q;
  assign bus.wr_store_sync_success = sync_q;
  assign bus.wr_cache_write_en     = we_q;
  assign bus.wr_cache_write_index  = idx_q;

endmodule
